// File: rtl/mul_if.sv
// Request/response bundle between the execute stage and the iterative multiplier.
// Signal set and handshake mirror the divide unit so the execute stage drives both alike.
interface mul_if;
   logic        enable;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   logic        mul;
   logic        mulh;
   logic        mulhsu;
   logic        mulhu;
   logic [31:0] result;
   logic        ready;

   modport master (
      output enable,
      output rdata1,
      output rdata2,
      output mul,
      output mulh,
      output mulhsu,
      output mulhu,
      input  result,
      input  ready
   );

   modport slave (
      input  enable,
      input  rdata1,
      input  rdata2,
      input  mul,
      input  mulh,
      input  mulhsu,
      input  mulhu,
      output result,
      output ready
   );
endinterface

// File: rtl/mul.sv
// Iterative radix-2 shift-add 32x32 multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// A 6-bit counter sequences capture (0), 32 add steps (1..32) and completion (33).
module mul (
   input  logic clk,
   input  logic rst,
   mul_if.slave bus
);

   localparam logic [5:0] CNT_IDLE = 6'd0;
   localparam logic [5:0] CNT_LAST = 6'd32;
   localparam logic [5:0] CNT_DONE = 6'd33;

   // Two's-complement magnitude of a 32-bit operand when it is treated as negative.
   function automatic logic [31:0] mag32(input logic [31:0] val, input logic neg);
      logic [31:0] res;
      if (neg) begin
         res = ~val + 32'd1;
      end else begin
         res = val;
      end
      return res;
   endfunction

   // Optional two's-complement negation of the full 64-bit product.
   function automatic logic [63:0] neg64(input logic [63:0] val, input logic neg);
      logic [63:0] res;
      if (neg) begin
         res = ~val + 64'd1;
      end else begin
         res = val;
      end
      return res;
   endfunction

   logic [5:0]  cnt_r,     cnt_s;
   logic [63:0] acc_r,     acc_s;
   logic [63:0] mcand_r,   mcand_s;
   logic [31:0] mplier_r,  mplier_s;
   logic        negativ_r, negativ_s;
   logic        op_hi_r,   op_hi_s;
   logic        ready_r,   ready_s;
   logic [31:0] result_r,  result_s;

   logic        signed1_s;
   logic        signed2_s;
   logic        neg1_s;
   logic        neg2_s;
   logic [31:0] mag1_s;
   logic [31:0] mag2_s;
   logic        any_op_s;
   logic [63:0] prod_s;

   // Operand sign handling for a request presented at the idle counter.
   always_comb begin
      signed1_s = bus.mulh | bus.mulhsu;
      signed2_s = bus.mulh;
      neg1_s    = signed1_s & bus.rdata1[31];
      neg2_s    = signed2_s & bus.rdata2[31];
      mag1_s    = mag32(bus.rdata1, neg1_s);
      mag2_s    = mag32(bus.rdata2, neg2_s);
      any_op_s  = bus.mul | bus.mulh | bus.mulhsu | bus.mulhu;
      prod_s    = neg64(acc_r, negativ_r);
   end

   // Counter-driven next-state: capture, shift-add steps and completion decode.
   always_comb begin
      cnt_s     = cnt_r;
      acc_s     = acc_r;
      mcand_s   = mcand_r;
      mplier_s  = mplier_r;
      negativ_s = negativ_r;
      op_hi_s   = op_hi_r;
      ready_s   = 1'b0;
      result_s  = 32'd0;

      case (cnt_r)
         CNT_IDLE: begin
            if (bus.enable) begin
               // mul wins over every high-half op, so any other set bit means the high word
               op_hi_s  = ~bus.mul;
               acc_s    = 64'd0;
               mcand_s  = {32'd0, mag1_s};
               mplier_s = mag2_s;
               if ((mag1_s == 32'd0) || (mag2_s == 32'd0) || !any_op_s) begin
                  negativ_s = 1'b0;
                  cnt_s     = CNT_DONE;
               end else begin
                  negativ_s = neg1_s ^ neg2_s;
                  cnt_s     = 6'd1;
               end
            end else begin
               cnt_s = CNT_IDLE;
            end
         end
         CNT_DONE: begin
            ready_s = 1'b1;
            if (op_hi_r) begin
               result_s = prod_s[63:32];
            end else begin
               result_s = prod_s[31:0];
            end
            cnt_s = CNT_IDLE;
         end
         default: begin
            if (cnt_r <= CNT_LAST) begin
               if (mplier_r[0]) begin
                  acc_s = acc_r + mcand_r;
               end else begin
                  acc_s = acc_r;
               end
               mcand_s  = {mcand_r[62:0], 1'b0};
               mplier_s = {1'b0, mplier_r[31:1]};
               cnt_s    = cnt_r + 6'd1;
            end else begin
               // Unreachable counter codes fall back to idle.
               cnt_s = CNT_IDLE;
            end
         end
      endcase
   end

   // State and registered outputs; asynchronous reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r     <= CNT_IDLE;
         acc_r     <= 64'd0;
         mcand_r   <= 64'd0;
         mplier_r  <= 32'd0;
         negativ_r <= 1'b0;
         op_hi_r   <= 1'b0;
         ready_r   <= 1'b0;
         result_r  <= 32'd0;
      end else begin
         cnt_r     <= cnt_s;
         acc_r     <= acc_s;
         mcand_r   <= mcand_s;
         mplier_r  <= mplier_s;
         negativ_r <= negativ_s;
         op_hi_r   <= op_hi_s;
         ready_r   <= ready_s;
         result_r  <= result_s;
      end
   end

   assign bus.ready  = ready_r;
   assign bus.result = result_r;

endmodule
